// File: rtl/country_car_sensor.sv
// -----------------------------------------------------------------------------
// country_car_sensor
//
// Conditions the raw country-road loop detector into the car-present request
// `x` consumed by sig_control. The detector level is synchronised with two
// flops, debounced by a four-state qualifier FSM, and turned into arrival and
// departure events. A saturating counter tracks vehicles still waiting (a
// departure only retires a vehicle while the country light is GREEN). The
// request is stretched by a hold timer so that closely spaced cars do not let
// the controller drop country GREEN between them.
//
// Optional feature (compile-time macro SENSOR_STUCK_DETECT_EN):
//   adds the sensor_fault output and an occupancy counter. A detector that
//   stays occupied for STUCK_CYCLES cycles is declared stuck: x is forced low,
//   car_count freezes, and the next departure clears the fault and empties
//   car_count. Without the macro there is no fault port and x is never forced.
//
// Parameters:
//   DEBOUNCE_CYCLES  qualifier length for a level change (>= 1)
//   HOLD_CYCLES      cycles x stays high after the request clears (>= 0)
//   COUNT_WIDTH      width of the waiting-vehicle counter
//   STUCK_CYCLES     occupancy limit before a stuck fault (>= 1)
//
// Ports:
//   clock         system clock, all state updates on the rising edge
//   clear         asynchronous active-high reset
//   sensor_raw    asynchronous raw detector level, 1 = metal over loop
//   country       country light from sig_control: RED=0 YELLOW=1 GREEN=2
//                 (3 is treated as not GREEN)
//   x             registered car-present request
//   car_count     number of vehicles waiting (saturating)
//   car_arrival   one-cycle pulse on the first OCCUPIED cycle of each arrival
//   sensor_fault  stuck-sensor flag (only with SENSOR_STUCK_DETECT_EN)
// -----------------------------------------------------------------------------
module country_car_sensor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 6,
    parameter int COUNT_WIDTH     = 4,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   sensor_raw,
    input  logic [1:0]             country,
    output logic                   x,
    output logic [COUNT_WIDTH-1:0] car_count,
    output logic                   car_arrival
`ifdef SENSOR_STUCK_DETECT_EN
    ,
    output logic                   sensor_fault
`endif
);

    // Reject parameter values the datapath cannot represent.
    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 0 || COUNT_WIDTH < 1 ||
        STUCK_CYCLES < 1) begin : g_bad_params
        $error("country_car_sensor: invalid parameter value");
    end

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] QUAL_ON  = 2'd1;
    localparam logic [1:0] OCCUPIED = 2'd2;
    localparam logic [1:0] QUAL_OFF = 2'd3;

    localparam logic [1:0] GREEN = 2'd2;

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    // Saturating helpers for the vehicle counter and the hold timer.
    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (v == COUNT_MAX) ? v : v + 1'b1;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_dec(input logic [COUNT_WIDTH-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    function automatic logic [HOLD_W-1:0] timer_dec(input logic [HOLD_W-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    logic                   sync_p0;
    logic                   sync_p1;
    logic                   s;
    logic [1:0]             state;
    logic [1:0]             state_n;
    logic [DB_W-1:0]        db_cnt;
    logic                   arrival;
    logic                   departure;
    logic [COUNT_WIDTH-1:0] count_n;
    logic [HOLD_W-1:0]      hold_timer;
    logic                   req;
    logic                   frozen;
    logic                   fault_n;

    // ---- stage p0/p1: two-flop synchroniser on the raw detector ----
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= sensor_raw;
            sync_p1 <= sync_p0;
        end
    end

    assign s = sync_p1;

    // ---- qualifier FSM: debounced level and arrival/departure events ----
    always_comb begin
        state_n   = state;
        arrival   = 1'b0;
        departure = 1'b0;
        case (state)
            IDLE: begin
                if (s) state_n = QUAL_ON;
            end
            QUAL_ON: begin
                if (!s) begin
                    state_n = IDLE;
                end else if (db_cnt == DB_LAST) begin
                    state_n = OCCUPIED;
                    arrival = 1'b1;
                end
            end
            OCCUPIED: begin
                if (!s) state_n = QUAL_OFF;
            end
            QUAL_OFF: begin
                // A bounce back to occupied is the same vehicle, not a new one.
                if (s) begin
                    state_n = OCCUPIED;
                end else if (db_cnt == DB_LAST) begin
                    state_n   = IDLE;
                    departure = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state  <= IDLE;
            db_cnt <= '0;
        end else begin
            state <= state_n;
            // The counter restarts on every state entry; it only advances while
            // a qualifying state keeps seeing its target level, so it never
            // exceeds DB_LAST.
            if (state_n != state) begin
                db_cnt <= '0;
            end else if (state == QUAL_ON || state == QUAL_OFF) begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

`ifdef SENSOR_STUCK_DETECT_EN
    localparam int OCC_W = $clog2(STUCK_CYCLES + 1);
    localparam logic [OCC_W-1:0] OCC_LAST = OCC_W'(STUCK_CYCLES - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(STUCK_CYCLES);

    logic [OCC_W-1:0] occ_cnt;
    logic             fault;

    always_comb begin
        fault_n = fault;
        if (fault && departure) begin
            fault_n = 1'b0;
        end else if (!fault && state == OCCUPIED && occ_cnt == OCC_LAST) begin
            fault_n = 1'b1;
        end
    end

    // Occupancy time accumulates across QUAL_OFF bounces of the same vehicle
    // and restarts only once the loop has been accepted as empty.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            occ_cnt <= '0;
            fault   <= 1'b0;
        end else begin
            fault <= fault_n;
            if (state == IDLE || state == QUAL_ON) begin
                occ_cnt <= '0;
            end else if (state == OCCUPIED && occ_cnt != OCC_FULL) begin
                occ_cnt <= occ_cnt + 1'b1;
            end
        end
    end

    assign frozen       = fault;
    assign sensor_fault = fault;
`else
    assign frozen  = 1'b0;
    assign fault_n = 1'b0;
`endif

    // ---- vehicle counter ----
    always_comb begin
        count_n = car_count;
        if (frozen) begin
            // A stuck detector gives no trustworthy history: its departure
            // empties the queue instead of retiring one vehicle.
            if (departure) count_n = '0;
        end else if (arrival) begin
            count_n = sat_inc(car_count);
        end else if (departure && country == GREEN) begin
            count_n = sat_dec(car_count);
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            car_count   <= '0;
            car_arrival <= 1'b0;
        end else begin
            car_count   <= count_n;
            car_arrival <= arrival;
        end
    end

    // ---- request stretch and registered x ----
    assign req = !frozen &&
                 ((car_count != '0) || state == OCCUPIED || state == QUAL_OFF);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            hold_timer <= '0;
            x          <= 1'b0;
        end else begin
            // The timer is emptied during a fault so that clearing the fault
            // does not release a stale stretched request.
            if (frozen) begin
                hold_timer <= '0;
            end else if (req) begin
                hold_timer <= HOLD_LOAD;
            end else begin
                hold_timer <= timer_dec(hold_timer);
            end
            x <= (req || (hold_timer != '0)) && !fault_n;
        end
    end

endmodule
